// File: rtl/crc8_frame_rx.sv
// 8N1 serial receiver that deframes fixed-length payload frames and checks a trailing CRC-8.
// Reports payload bytes, per-frame CRC result and a saturating error count.
module crc8_frame_rx #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned PAYLOAD_LEN = 4,
    parameter logic [7:0]  POLY        = 8'h07,
    parameter logic [7:0]  CRC_INIT    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned TMO  = 20 * DIV;
    localparam int unsigned TW   = $clog2(DIV + 1);
    localparam int unsigned GW   = $clog2(TMO + 1);
    localparam logic [TW-1:0] HALF_M1 = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);
    localparam logic [GW-1:0] TMO_M1  = GW'(TMO - 1);
    localparam logic [7:0]    PLEN    = 8'(PAYLOAD_LEN);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, bc_q, bc_d, crc_q, crc_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    data_q, data_d, errc_q, errc_d;
    logic          dv_q, dv_d, fd_q, fd_d, ok_q, ok_d, fe_q, fe_d, busy_q, busy_d;
    logic          accept, abort, err_inc;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ POLY) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        sync1_d    = rxd;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;
        timer_d    = timer_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        bc_d       = bc_q;
        crc_d      = crc_q;
        gap_d      = gap_q;
        data_d     = data_q;
        errc_d     = errc_q;
        ok_d       = ok_q;
        busy_d     = busy_q;
        dv_d       = 1'b0;
        fd_d       = 1'b0;
        fe_d       = 1'b0;
        accept     = 1'b0;
        abort      = 1'b0;
        err_inc    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Edge needs a high prior sample, so a low line after a bad stop is ignored.
                if (rxs_prev_q && !rxs_q) begin
                    state_d = StStart;
                    timer_d = HALF_M1;
                end
            end
            StStart: begin
                if (timer_q == '0) begin
                    if (rxs_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        timer_d = DIV_M1;
                        bit_d   = 3'd0;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StData: begin
                if (timer_q == '0) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    timer_d = DIV_M1;
                    if (bit_q == 3'd7) state_d = StStop;
                    else bit_d = bit_q + 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StStop: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                    if (rxs_q) begin
                        accept = 1'b1;
                    end else begin
                        fe_d    = 1'b1;
                        abort   = 1'b1;
                        err_inc = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            if (bc_q == PLEN) begin
                ok_d    = (shift_q == crc_q);
                fd_d    = 1'b1;
                err_inc = (shift_q != crc_q);
                bc_d    = 8'd0;
                crc_d   = CRC_INIT;
                busy_d  = 1'b0;
            end else begin
                data_d = shift_q;
                dv_d   = 1'b1;
                crc_d  = crc8_step(crc_q, shift_q);
                bc_d   = bc_q + 1'b1;
                busy_d = 1'b1;
            end
        end

        // Inter-byte gap watchdog; only counts between bytes of a started frame.
        if (busy_q && state_q == StIdle) begin
            if (gap_q == TMO_M1) begin
                gap_d   = '0;
                fe_d    = 1'b1;
                abort   = 1'b1;
                err_inc = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end else begin
            gap_d = '0;
        end

        if (abort) begin
            bc_d   = 8'd0;
            crc_d  = CRC_INIT;
            busy_d = 1'b0;
        end
        if (err_inc && errc_q != 8'hFF) errc_d = errc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            timer_q    <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            bc_q       <= 8'd0;
            crc_q      <= CRC_INIT;
            gap_q      <= '0;
            data_q     <= 8'd0;
            errc_q     <= 8'd0;
            dv_q       <= 1'b0;
            fd_q       <= 1'b0;
            ok_q       <= 1'b0;
            fe_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            bc_q       <= bc_d;
            crc_q      <= crc_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            errc_q     <= errc_d;
            dv_q       <= dv_d;
            fd_q       <= fd_d;
            ok_q       <= ok_d;
            fe_q       <= fe_d;
            busy_q     <= busy_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign frame_done = fd_q;
    assign crc_ok     = ok_q;
    assign frame_err  = fe_q;
    assign err_count  = errc_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_crc8_frame_rx.sv
// Bench for crc8_frame_rx: table vectors, random frames against a polynomial-division model,
// and hand sequences for framing error, glitch, timeout, reset mid-frame and saturation.
module tb_crc8_frame_rx;

    localparam int unsigned CLK_HZ = 40;
    localparam int unsigned BAUD   = 10;
    localparam int unsigned DIV    = CLK_HZ / BAUD;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] p0, p1, p2, p3, crc;
        logic       ok;
    } vec_t;

    logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1, rxd9 = 1'b1;
    logic [7:0] data, err_count, data9, err_count9;
    logic       data_valid, frame_done, crc_ok, frame_err, busy;
    logic       data_valid9, frame_done9, crc_ok9, frame_err9, busy9;

    always #5 clk = ~clk;

    crc8_frame_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PAYLOAD_LEN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .data(data), .data_valid(data_valid),
        .frame_done(frame_done), .crc_ok(crc_ok), .frame_err(frame_err),
        .err_count(err_count), .busy(busy)
    );

    crc8_frame_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PAYLOAD_LEN(9)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd9), .data(data9), .data_valid(data_valid9),
        .frame_done(frame_done9), .crc_ok(crc_ok9), .frame_err(frame_err9),
        .err_count(err_count9), .busy(busy9)
    );

    int checks = 0, errors = 0;
    int fe_cnt = 0, exp_fe = 0, fd9_cnt = 0;
    int exp_err = 0;
    logic [7:0] got_data[$];
    logic       got_ok[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC as the remainder of message * x^8 divided by the generator, by long division.
    function automatic logic [7:0] ref_crc(input bq_t p);
        bit       bits[$];
        bit [8:0] gen;
        logic [7:0] r;
        logic [7:0] init;
        init = 8'h00;
        gen  = {1'b1, 8'h07};
        foreach (p[k]) for (int i = 7; i >= 0; i--) bits.push_back(p[k][i]);
        for (int i = 0; i < 8; i++) bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits[i] = bits[i] ^ init[7-i];
        for (int i = 0; i + 8 < bits.size(); i++) begin
            if (bits[i]) for (int j = 0; j < 9; j++) bits[i+j] = bits[i+j] ^ gen[8-j];
        end
        for (int i = 0; i < 8; i++) r[7-i] = bits[bits.size()-8+i];
        return r;
    endfunction

    logic dv_prev = 0, fd_prev = 0, fe_prev = 0, ok_prev = 0, rst_prev = 0;
    logic [7:0] data_prev = 0;
    always @(negedge clk) begin
        if (data_valid) begin
            got_data.push_back(data);
            chk("dv_width", dv_prev, 0);
        end
        if (frame_done) begin
            got_ok.push_back(crc_ok);
            chk("fd_width", fd_prev, 0);
        end
        if (frame_err) begin
            fe_cnt++;
            chk("fe_width", fe_prev, 0);
        end
        if (frame_done9) fd9_cnt++;
        if (rst_n && rst_prev && data !== data_prev) chk("data_hold", data_valid, 1);
        if (rst_n && rst_prev && crc_ok !== ok_prev) chk("ok_hold", frame_done, 1);
        dv_prev = data_valid; fd_prev = frame_done; fe_prev = frame_err;
        data_prev = data; ok_prev = crc_ok; rst_prev = rst_n;
    end

    task automatic drive(input logic v, input bit line9);
        if (line9) rxd9 = v;
        else rxd = v;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit line9);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(fr[i], line9);
            repeat (DIV) @(negedge clk);
        end
        drive(1'b1, line9);
    endtask

    task automatic send_frame(input bq_t bytes, input bit line9);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1, line9);
        repeat (3 * DIV) @(negedge clk);
    endtask

    task automatic expect_frame(input bq_t pay, input logic exp_ok, input string tag);
        @(posedge clk); #1;
        chk({tag, "_nbytes"}, got_data.size(), pay.size());
        for (int i = 0; i < pay.size() && i < got_data.size(); i++)
            chk({tag, "_data"}, got_data[i], pay[i]);
        chk({tag, "_nframes"}, got_ok.size(), 1);
        chk({tag, "_crc_ok"}, crc_ok, exp_ok);
        if (!exp_ok && exp_err < 255) exp_err++;
        chk({tag, "_err_count"}, err_count, exp_err);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_err"}, fe_cnt, exp_fe);
        got_data.delete();
        got_ok.delete();
        @(negedge clk);
    endtask

    task automatic run_frame(input bq_t pay, input logic [7:0] crc, input logic exp_ok,
                             input string tag);
        bq_t full;
        full = pay;
        full.push_back(crc);
        send_frame(full, 1'b0);
        expect_frame(pay, exp_ok, tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_dv"}, data_valid, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_ok"}, crc_ok, 0);
        chk({tag, "_fe"}, frame_err, 0);
        chk({tag, "_errc"}, err_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        bq_t  pay, good;
        logic [7:0] c;

        tbl[0] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h07, 1'b1};
        tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h06, 1'b0};
        tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h0E, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h89, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h88, 1'b0};
        good = '{8'h00, 8'h00, 8'h00, 8'h01};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        foreach (tbl[i]) begin
            pay = '{tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].p3};
            run_frame(pay, tbl[i].crc, tbl[i].ok, "table");
        end

        for (int n = 0; n < 12; n++) begin
            pay.delete();
            for (int i = 0; i < 4; i++) pay.push_back(8'($urandom_range(0, 255)));
            c = ref_crc(pay);
            if ($urandom_range(0, 2) == 0) begin
                c = c ^ 8'($urandom_range(1, 255));
                run_frame(pay, c, 1'b0, "rand_bad");
            end else begin
                run_frame(pay, c, 1'b1, "rand_good");
            end
        end

        // Standard check value over "123456789" on the 9-byte instance.
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
        send_frame(pay, 1'b1);
        @(posedge clk); #1;
        chk("check_fd", fd9_cnt, 1);
        chk("check_ok", crc_ok9, 1);
        chk("check_errc", err_count9, 0);
        pay[9] = 8'hF5;
        send_frame(pay, 1'b1);
        @(posedge clk); #1;
        chk("check_bad_fd", fd9_cnt, 2);
        chk("check_bad_ok", crc_ok9, 0);
        chk("check_bad_errc", err_count9, 1);
        @(negedge clk);

        // Short glitch on idle line: no strobes.
        rxd = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        @(posedge clk); #1;
        chk("glitch_nbytes", got_data.size(), 0);
        chk("glitch_nframes", got_ok.size(), 0);
        chk("glitch_fe", fe_cnt, exp_fe);
        chk("glitch_errc", err_count, exp_err);
        @(negedge clk);

        // Bad stop bit on the third byte of a frame.
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (3 * DIV) @(negedge clk);
        exp_fe++;
        if (exp_err < 255) exp_err++;
        @(posedge clk); #1;
        chk("ferr_fe", fe_cnt, exp_fe);
        chk("ferr_errc", err_count, exp_err);
        chk("ferr_busy", busy, 0);
        chk("ferr_nbytes", got_data.size(), 2);
        got_data.delete();
        @(negedge clk);
        run_frame(good, 8'h07, 1'b1, "after_ferr");

        // Two bytes then a long gap.
        send_byte(8'hA1, 1'b1, 1'b0);
        send_byte(8'hB2, 1'b1, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        chk("tmo_busy_before", busy, 1);
        chk("tmo_fe_before", fe_cnt, exp_fe);
        repeat (23 * DIV) @(negedge clk);
        exp_fe++;
        if (exp_err < 255) exp_err++;
        @(posedge clk); #1;
        chk("tmo_fe", fe_cnt, exp_fe);
        chk("tmo_errc", err_count, exp_err);
        chk("tmo_busy", busy, 0);
        got_data.delete();
        @(negedge clk);
        run_frame(good, 8'h07, 1'b1, "after_tmo");

        // Reset in the middle of data bit 4 of byte 2.
        send_byte(8'h3C, 1'b1, 1'b0);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = i[0];
            repeat (DIV) @(negedge clk);
        end
        rxd = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("mid_reset");
        @(negedge clk);
        rxd = 1'b1;
        rst_n = 1'b1;
        got_data.delete();
        got_ok.delete();
        exp_err = 0;
        exp_fe = fe_cnt;
        repeat (30 * DIV) @(negedge clk);
        @(posedge clk); #1;
        chk("post_reset_nbytes", got_data.size(), 0);
        chk("post_reset_fe", fe_cnt, exp_fe);
        chk("post_reset_busy", busy, 0);
        @(negedge clk);
        run_frame(good, 8'h07, 1'b1, "after_reset");

        // Saturation of the error counter.
        for (int n = 0; n < 260; n++) begin
            pay.delete();
            for (int i = 0; i < 4; i++) pay.push_back(8'($urandom_range(0, 255)));
            run_frame(pay, ref_crc(pay) ^ 8'h01, 1'b0, "sat");
        end
        chk("sat_final", err_count, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_frame_rx.md
# crc8_frame_rx

Serial-line receiver and CRC checker: the far end of the CRC-framed link the board transmits. Deframes 8N1 asynchronous bytes from a single line input, collects fixed-length frames of `PAYLOAD_LEN` data bytes followed by one CRC-8 byte, and recomputes the CRC over the payload. Sits between the board pin (JD4-style input) and the display/LED logic. Reports each payload byte, per-frame CRC pass/fail, and a saturating error count.

## Interface

**Parameters**
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 115200: line bit rate. `DIV = CLK_HZ/BAUD` (integer division; 434 at defaults).
- `PAYLOAD_LEN`, default 4: data bytes per frame (1..255).
- `POLY`, default 8'h07: CRC-8 polynomial, MSB-first, non-reflected.
- `CRC_INIT`, default 8'h00: CRC preset at frame start. No final XOR.

**Ports**
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial line, idle high, asynchronous to `clk`.
- `data` out 8: last received payload byte.
- `data_valid` out 1: one-cycle pulse when `data` updates.
- `frame_done` out 1: one-cycle pulse after the CRC byte is received.
- `crc_ok` out 1: result of the last completed frame, held until the next `frame_done`.
- `frame_err` out 1: one-cycle pulse on a stop-bit error or an inter-byte timeout.
- `err_count` out 8: count of CRC mismatches plus `frame_err` events, saturating at 255.
- `busy` out 1: high while a frame is partially received.

## Operation

**Input synchronisation**
- `rxd` passes through a 2-FF synchroniser; both flops reset to 1.
- All logic uses the synchronised value `rxs`.

**Byte FSM: IDLE → START → DATA → STOP → IDLE**
- **IDLE:** a falling edge on `rxs` enters START and loads the bit timer with `DIV/2`.
- **START:** when the timer expires, sample `rxs`.
  - 1: false start, return to IDLE with no output.
  - 0: enter DATA, timer = `DIV`.
- **DATA:** sample 8 bits at `DIV` intervals, LSB first, into a shift register.
- **STOP:** sample once after `DIV`.
  - 1: byte accepted.
  - 0: framing error. Pulse `frame_err`, abort the frame (byte counter 0, CRC = `CRC_INIT`), return to IDLE.
  - A new start edge is detected only once `rxs` has been high again.

**Frame assembly** (byte counter `bc`, 0..`PAYLOAD_LEN`)
- **`bc < PAYLOAD_LEN`:**
  - `data` ← byte; pulse `data_valid`.
  - `crc` ← CRC8(`crc`, byte): bitwise MSB-first update, completed in the accept cycle.
  - `bc` increments; `busy` = 1.
- **`bc == PAYLOAD_LEN`:**
  - `crc_ok` ← (byte == `crc`); pulse `frame_done`.
  - On mismatch, `err_count` += 1 (saturating).
  - `bc` ← 0, `crc` ← `CRC_INIT`, `busy` = 0.
- **Timeout:** while `busy` and the FSM is in IDLE, a gap counter runs. Reaching `20*DIV` clocks (2 character times) pulses `frame_err`, increments `err_count`, and aborts the frame.
- **Simultaneous events:** `frame_err` and a CRC-mismatch increment can never occur in the same cycle. `err_count` at 255 stays 255.

## Timing
- **Reset values:** `data` = 0, `data_valid` = 0, `frame_done` = 0, `crc_ok` = 0, `frame_err` = 0, `err_count` = 0, `busy` = 0, FSM = IDLE, `crc` = `CRC_INIT`, `bc` = 0.
- **Synchroniser:** 2 cycles from `rxd` to `rxs`.
- **Sample points:** start-bit mid-point at `DIV/2` after the detected edge; each following sample at +`DIV`.
- **Byte outputs:** `data_valid`/`frame_done`/`frame_err` assert in the cycle after the stop-bit sample, all exactly 1 cycle wide.
- **Registered outputs:** `data` and `crc_ok` change only in the same cycle as their strobe. `busy` rises with the first `data_valid`.
- **Back-to-back bytes:** a start bit immediately following a stop bit (zero idle) is received without loss.
- **Reset mid-byte or mid-frame:** all state returns to reset values immediately. The partial frame is discarded with no strobes.

## Test plan
1. **Good frame.** `PAYLOAD_LEN` = 4, frame 00 00 00 01 07 at 115200 baud → four `data_valid` pulses with `data` = 00, 00, 00, 01; `frame_done` pulse; `crc_ok` = 1; `err_count` = 0; `busy` low afterwards.
2. **Standard check value.** `PAYLOAD_LEN` = 9, "123456789" (31..39) followed by F4 → `crc_ok` = 1. The same frame with F5 as the CRC byte → `crc_ok` = 0, `err_count` = 1.
3. **Framing error.** Send byte 0x55 with the stop bit forced to 0 mid-frame → `frame_err` pulse, `err_count` += 1, `busy` = 0. A following good frame is accepted with `crc_ok` = 1.
4. **Glitch and timeout.** A 0-pulse of `DIV/4` on an idle line → no output. Send 2 payload bytes, then idle for 25 bit times → `frame_err` once, `bc` reset; the next full good frame gives `crc_ok` = 1.
5. **Saturation.** 260 frames with a bad CRC → `err_count` reaches 255 and holds.
6. **Reset mid-frame.** Pulse `rst_n` low for 3 cycles in the middle of data bit 4 of byte 2 → all outputs at reset values. A complete good frame afterwards passes.
